// File: rtl/wb_arbiter.sv
// Writeback arbiter: one result FIFO per execute unit, drained round-robin onto one scoreboard port.
// Latency: an entry pushed in cycle N can be offered on wb_* in cycle N+1 at the earliest; one entry retires per cycle.
// Backpressure: wb_ready_i low holds the offered entry stable; req_ready_o[k] drops while FIFO k is full.
module wb_arbiter #(
    parameter int unsigned NR_REQ = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [NR_REQ-1:0]           req_valid_i,
    input  logic [NR_REQ*DATA_W-1:0]    req_data_i,
    input  logic [NR_REQ*ID_W-1:0]      req_id_i,
    input  logic [NR_REQ-1:0]           req_ex_i,
    output logic [NR_REQ-1:0]           req_ready_o,
    output logic                        wb_valid_o,
    output logic [DATA_W-1:0]           wb_data_o,
    output logic [ID_W-1:0]             wb_id_o,
    output logic                        wb_ex_o,
    output logic [$clog2(NR_REQ)-1:0]   wb_src_o,
    input  logic                        wb_ready_i,
    output logic [NR_REQ-1:0]           overflow_o
);

    localparam int unsigned SRC_W = $clog2(NR_REQ);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NR_REQ - 1);

    typedef struct packed {
        logic              ex;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t         head [NR_REQ];
    logic [NR_REQ-1:0] not_empty;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  grant_nxt;
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [SRC_W-1:0]  lock_idx_q;
    logic              lock_q;
    logic              any_vld;
    logic              wb_hs;

    assign any_vld   = |not_empty;
    assign wb_hs     = any_vld && wb_ready_i;
    assign grant_nxt = (grant == LAST_SRC) ? '0 : grant + SRC_W'(1);

    // Scan downwards so the candidate closest to rr_ptr_q is the last one to win.
    always_comb begin
        grant = rr_ptr_q;
        cand  = '0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int i = NR_REQ - 1; i >= 0; i--) begin
                cand = SRC_W'((int'(rr_ptr_q) + i) % int'(NR_REQ));
                if (not_empty[cand]) begin
                    grant = cand;
                end
            end
        end
    end

    always_comb begin
        wb_valid_o = any_vld;
        wb_data_o  = '0;
        wb_id_o    = '0;
        wb_ex_o    = 1'b0;
        wb_src_o   = '0;
        if (any_vld) begin
            wb_data_o = head[grant].data;
            wb_id_o   = head[grant].id;
            wb_ex_o   = head[grant].ex;
            wb_src_o  = grant;
        end
    end

    // A stalled offer pins the grant so the scoreboard sees a stable entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (wb_hs) begin
            rr_ptr_q   <= grant_nxt;
            lock_q     <= 1'b0;
        end else if (any_vld) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant;
        end
    end

    for (genvar k = 0; k < NR_REQ; k++) begin : g_fifo
        wb_entry_t        mem_q [DEPTH];
        wb_entry_t        wr_ent;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [PTR_W-1:0] wr_ptr_q;
        logic [CNT_W-1:0] cnt_q;
        logic             full;
        logic             push;
        logic             pop;
        logic             ovf_q;

        assign full   = (cnt_q == FULL_CNT);
        assign push   = req_valid_i[k] && !full && !flush_i;
        assign pop    = wb_hs && (grant == SRC_W'(k)) && !flush_i;
        assign wr_ent = '{ex:   req_ex_i[k],
                          id:   req_id_i[k*ID_W +: ID_W],
                          data: req_data_i[k*DATA_W +: DATA_W]};

        assign head[k]        = mem_q[rd_ptr_q];
        assign not_empty[k]   = (cnt_q != '0);
        assign req_ready_o[k] = !full;
        assign overflow_o[k]  = ovf_q;

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_ent;
            end
        end

        // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
            end else if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ovf_q <= req_valid_i[k] && full;
            end
        end
    end

endmodule
